control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer directly upstream of the datapath. Latches
//  current_instruction, decodes it, and drives the datapath's ALU/select/load/store
//  strobes and program_counter_increment. Also stalls on VGA plot handshakes.
//  Register 0 is the program counter. Controls change on posedge clock; the
//  datapath commits on the following negedge.
// PARAMETERS
//  PLOT_TIMEOUT  255  cycles in S_PLOT without vga_done before abort + fault
// PORTS
//  clock                     in   1   system clock, posedge
//  resetn                    in   1   synchronous active-low reset
//  current_instruction       in   16  instruction at PC, from datapath
//  zeroflag                  in   16  per-register zero flags
//  signflag                  in   16  per-register sign flags
//  vga_done                  in   1   plotter accepted pixel
//  program_counter_increment out  1   add 1 to r0 at next commit
//  alu_op                    out  4   ALU operation
//  alu_a_altern              out  16  immediate operand A
//  alu_b_altern              out  16  immediate operand B (always 0)
//  alu_a_select/alu_b_select out  4   register operand selects
//  alu_a_source/alu_b_source out  1   1 = use altern operand
//  alu_out_select            out  4   destination register
//  alu_load_src              out  2   00 none, 01 ALU, 10 memory
//  alu_store_to_mem          out  1   store selected_c to mem[alu_output]
//  alu_store_to_stk          out  1   tied 0 in this revision
//  vga_color_select/vga_coord_select out 4  plot source registers
//  vga_plot                  out  1   plot request (level)
//  halted                    out  1   sequencer in S_HALT
//  fault                     out  1   sticky: illegal opcode or plot timeout
//  retired                   out  16  count of retired instructions
// BEHAVIOUR
//  Encoding: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb; imm8 = [7:0].
//  Ops: 0 NOP; 1-7 ALU rd=ra op rb (alu_op=op); 8 LDI rd=zext(imm8) (a_source=1,
//   alu_op=OP_PASS); 9 LD rd=mem[ra]; A ST mem[ra]=rd; B JZ if zeroflag[ra]
//   r0=rb else PC+1; C JN same on signflag; D PLOT color=ra coord=rb; F HALT;
//   E illegal -> fault=1, S_HALT.
//  Reset: state S_FETCH; ir=0; all outputs 0; retired=0; fault=0; halted=0.
//  States: S_FETCH (1 cyc) latch ir<=current_instruction, outputs idle.
//   S_EXEC (1 cyc): drive decoded strobes for exactly this cycle. Non-jump:
//   program_counter_increment=1 in same cycle. Taken jump: load_src=01,
//   out_select=0, a_select=rb, op=OP_PASS, increment=0. Not taken: increment=1.
//   Next: S_FETCH, or S_PLOT for op D, S_HALT for F/E.
//  S_PLOT: vga_plot=1, selects held; on vga_done: increment=1 that cycle, ->S_FETCH.
//   Timeout counter reaches PLOT_TIMEOUT: fault=1, increment=1, ->S_FETCH.
//   vga_done outside S_PLOT ignored; counter clears on entry.
//  S_HALT: all strobes 0, halted=1, exits only on reset.
//  Latency: 2 cycles/instruction, 2+N for PLOT waiting N cycles.
//  retired += 1 (wrapping at 16'hFFFF->0) on every cycle increment or taken jump fires.
//  Never assert store and load in the same cycle; ALU with rd=0 is a jump, increment=0.
//  resetn low mid-instruction: state to S_FETCH next edge, pending plot dropped.
// STRUCTURE
//  Package control_pkg: state enum, opcode constants (OP_NOP..OP_HALT), OP_PASS=4'h0,
//  instruction field positions. One sub-module: instr_decoder (combinational ir ->
//  strobe bundle); FSM, timeout counter and retired counter live in top.
// TESTING
//  LDI r3,0x5A -> EXEC: out_select=3, load_src=01, a_altern=16'h005A, increment=1; retired=1.
//  ADD-class op 2, rd=4 ra=1 rb=2 -> alu_op=2, a_select=1, b_select=2, 2 cycles total.
//  JZ ra=5 rb=6 with zeroflag[5]=1 -> out_select=0, increment=0; zeroflag[5]=0 -> increment=1.
//  PLOT, vga_done at wait cycle 3 -> vga_plot high 3 cycles, then FETCH; PLOT_TIMEOUT=4,
//   no done -> fault=1 after 4 cycles, increment=1.
//  Op E -> fault=1, halted=1, strobes 0 forever; resetn=0 one cycle -> S_FETCH, fault=0.
//  resetn low during S_PLOT -> vga_plot=0 next edge, retired=0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared types and constants for the control sequencer
// Purpose: FSM state enum, opcode constants, instruction field positions,
//          load-source encodings and the decoded strobe bundle.
// Ports:   none (package).
package control_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_PLOT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU_1 = 4'h1;
  localparam logic [3:0] OP_ALU_7 = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_LD    = 4'h9;
  localparam logic [3:0] OP_ST    = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JN    = 4'hC;
  localparam logic [3:0] OP_PLOT  = 4'hD;
  localparam logic [3:0] OP_ILL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU pass-through of operand A
  localparam logic [3:0] OP_PASS  = 4'h0;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_ALU  = 2'b01;
  localparam logic [1:0] LOAD_MEM  = 2'b10;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [15:0] a_altern;
    logic [3:0]  a_select;
    logic [3:0]  b_select;
    logic        a_source;
    logic [3:0]  out_select;
    logic [1:0]  load_src;
    logic        store_to_mem;
    logic        pc_inc;
    logic        jump;
    logic [3:0]  color_select;
    logic [3:0]  coord_select;
    logic        is_plot;
    logic        is_halt;
    logic        is_illegal;
  } strobes_t;

endpackage

// File: rtl/control_sequencer_decoder.sv
// rtl/control_sequencer_decoder.sv - combinational instruction decoder
// Purpose: turns the latched instruction (plus jump flags) into the strobe
//          bundle the sequencer drives during its execute cycle.
// Ports:   ir        in  16  latched instruction
//          zeroflag  in  16  per-register zero flags
//          signflag  in  16  per-register sign flags
//          strobes   out     decoded strobe bundle
module instr_decoder
  import control_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [15:0] zeroflag,
  input  logic [15:0] signflag,
  output strobes_t    strobes
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [7:0] imm8;

  assign op   = ir[OP_MSB:OP_LSB];
  assign rd   = ir[RD_MSB:RD_LSB];
  assign ra   = ir[RA_MSB:RA_LSB];
  assign rb   = ir[RB_MSB:RB_LSB];
  assign imm8 = ir[IMM_MSB:0];

  strobes_t s;
  logic     writes_pc;

  always_comb begin
    s = '0;
    case (op)
      OP_NOP: ;
      OP_LDI: begin
        s.alu_op     = OP_PASS;
        s.a_source   = 1'b1;
        s.a_altern   = {8'h00, imm8};
        s.out_select = rd;
        s.load_src   = LOAD_ALU;
      end
      OP_LD: begin
        s.alu_op     = OP_PASS;
        s.a_select   = ra;
        s.out_select = rd;
        s.load_src   = LOAD_MEM;
      end
      OP_ST: begin
        // address comes through the ALU from ra; store data is read via out_select
        s.alu_op       = OP_PASS;
        s.a_select     = ra;
        s.out_select   = rd;
        s.store_to_mem = 1'b1;
      end
      OP_JZ, OP_JN: begin
        if ((op == OP_JZ) ? zeroflag[ra] : signflag[ra]) begin
          s.alu_op     = OP_PASS;
          s.a_select   = rb;
          s.out_select = 4'h0;
          s.load_src   = LOAD_ALU;
        end
      end
      OP_PLOT: begin
        s.color_select = ra;
        s.coord_select = rb;
        s.is_plot      = 1'b1;
      end
      OP_ILL:  s.is_illegal = 1'b1;
      OP_HALT: s.is_halt    = 1'b1;
      default: begin
        s.alu_op     = op;
        s.a_select   = ra;
        s.b_select   = rb;
        s.out_select = rd;
        s.load_src   = LOAD_ALU;
      end
    endcase

    // Any register load targeting r0 rewrites the PC, so it replaces the increment.
    writes_pc = (s.load_src != LOAD_NONE) && (s.out_select == 4'h0);
    s.jump    = writes_pc;
    // Plot advances the PC later, from S_PLOT; halt/illegal never advance it.
    s.pc_inc  = !(s.is_plot || s.is_halt || s.is_illegal) && !writes_pc;
  end

  assign strobes = s;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle instruction sequencer ahead of the datapath
// Purpose: fetch/execute FSM that latches the instruction at the PC, drives the
//          datapath strobes for one execute cycle, stalls on VGA plots with a
//          timeout, and counts retired instructions.
// Ports:   clock, resetn (sync, active low)
//          current_instruction, zeroflag, signflag, vga_done  (inputs)
//          program_counter_increment, alu_* strobes, vga_* selects/plot,
//          halted, fault (sticky), retired (16-bit wrapping count)  (outputs)
module control_sequencer
  import control_pkg::*;
#(
  parameter int PLOT_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] current_instruction,
  input  logic [15:0] zeroflag,
  input  logic [15:0] signflag,
  input  logic        vga_done,
  output logic        program_counter_increment,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a_altern,
  output logic [15:0] alu_b_altern,
  output logic [3:0]  alu_a_select,
  output logic [3:0]  alu_b_select,
  output logic        alu_a_source,
  output logic        alu_b_source,
  output logic [3:0]  alu_out_select,
  output logic [1:0]  alu_load_src,
  output logic        alu_store_to_mem,
  output logic        alu_store_to_stk,
  output logic [3:0]  vga_color_select,
  output logic [3:0]  vga_coord_select,
  output logic        vga_plot,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  localparam int CW = (PLOT_TIMEOUT < 2) ? 1 : $clog2(PLOT_TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic [CW-1:0] plot_cnt;
  logic        fault_q;
  logic [15:0] retired_q;
  logic        set_fault;
  logic        retire;
  logic        plot_timeout;
  strobes_t    dec;

  instr_decoder u_decoder (
    .ir       (ir),
    .zeroflag (zeroflag),
    .signflag (signflag),
    .strobes  (dec)
  );

  // plot_cnt is 0 in the first S_PLOT cycle, so this fires in wait cycle PLOT_TIMEOUT
  assign plot_timeout = (plot_cnt == CW'(PLOT_TIMEOUT - 1));

  always_comb begin
    state_next                = state;
    set_fault                 = 1'b0;
    retire                    = 1'b0;
    program_counter_increment = 1'b0;
    alu_op                    = 4'h0;
    alu_a_altern              = 16'h0000;
    alu_a_select              = 4'h0;
    alu_b_select              = 4'h0;
    alu_a_source              = 1'b0;
    alu_out_select            = 4'h0;
    alu_load_src              = LOAD_NONE;
    alu_store_to_mem          = 1'b0;
    vga_color_select          = 4'h0;
    vga_coord_select          = 4'h0;
    vga_plot                  = 1'b0;

    case (state)
      S_FETCH: state_next = S_EXEC;

      S_EXEC: begin
        program_counter_increment = dec.pc_inc;
        alu_op                    = dec.alu_op;
        alu_a_altern              = dec.a_altern;
        alu_a_select              = dec.a_select;
        alu_b_select              = dec.b_select;
        alu_a_source              = dec.a_source;
        alu_out_select            = dec.out_select;
        alu_load_src              = dec.load_src;
        alu_store_to_mem          = dec.store_to_mem;
        vga_color_select          = dec.color_select;
        vga_coord_select          = dec.coord_select;
        retire                    = dec.pc_inc || dec.jump;
        if (dec.is_illegal) begin
          set_fault  = 1'b1;
          state_next = S_HALT;
        end else if (dec.is_halt) begin
          state_next = S_HALT;
        end else if (dec.is_plot) begin
          state_next = S_PLOT;
        end else begin
          state_next = S_FETCH;
        end
      end

      S_PLOT: begin
        vga_plot         = 1'b1;
        vga_color_select = dec.color_select;
        vga_coord_select = dec.coord_select;
        if (vga_done) begin
          program_counter_increment = 1'b1;
          retire                    = 1'b1;
          state_next                = S_FETCH;
        end else if (plot_timeout) begin
          // abandon the pixel but still step past the PLOT instruction
          set_fault                 = 1'b1;
          program_counter_increment = 1'b1;
          retire                    = 1'b1;
          state_next                = S_FETCH;
        end
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_FETCH;
      ir        <= 16'h0000;
      plot_cnt  <= '0;
      fault_q   <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == S_FETCH) begin
        ir <= current_instruction;
      end
      // held at zero outside S_PLOT so each plot starts a fresh count
      if (state == S_PLOT) begin
        plot_cnt <= plot_cnt + 1'b1;
      end else begin
        plot_cnt <= '0;
      end
      fault_q <= fault_q | set_fault;
      if (retire) begin
        retired_q <= retired_q + 16'h0001;
      end
    end
  end

  assign alu_b_altern     = 16'h0000;
  assign alu_b_source     = 1'b0;
  assign alu_store_to_stk = 1'b0;
  assign halted           = (state == S_HALT);
  assign fault            = fault_q;
  assign retired          = retired_q;

endmodule
